// File: rtl/rggen_bit_field_access_arbiter.sv
// Round-robin arbiter that shares one register access port between N requesters.
// Optional acknowledge timeout is built when RGGEN_ACCESS_ARBITER_TIMEOUT_EN is defined.
module rggen_bit_field_access_arbiter #(
    parameter int N       = 2,
    parameter int WIDTH   = 32,
    parameter int TIMEOUT = 255
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic [N-1:0]         i_request,
    input  logic [N-1:0]         i_write,
    input  logic [N*WIDTH-1:0]   i_write_data,
    input  logic [N*WIDTH-1:0]   i_write_mask,
    output logic [N-1:0]         o_done,
    output logic [N-1:0]         o_error,
    output logic [WIDTH-1:0]     o_read_data,
    output logic [N-1:0]         o_grant,
    output logic                 o_valid,
    output logic                 o_write,
    output logic [WIDTH-1:0]     o_write_data,
    output logic [WIDTH-1:0]     o_write_mask,
    input  logic                 i_ack,
    input  logic [WIDTH-1:0]     i_read_data
);

    localparam int IDXW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        DONE
    } state_t;

    state_t          state;
    state_t          state_next;
    logic [IDXW-1:0] pointer;
    logic [IDXW-1:0] grant_idx;
    logic [IDXW-1:0] winner_idx;
    logic            winner_found;
    logic [N-1:0]    grant;
    logic            timeout_hit;

    // First requester at or above the pointer, wrapping around.
    always_comb begin
        int cand;
        cand         = 0;
        winner_found = 1'b0;
        winner_idx   = '0;
        for (int i = 0; i < N; i++) begin
            cand = (int'(pointer) + i) % N;
            if (!winner_found && i_request[IDXW'(cand)]) begin
                winner_found = 1'b1;
                winner_idx   = IDXW'(cand);
            end
        end
    end

`ifdef RGGEN_ACCESS_ARBITER_TIMEOUT_EN
    logic [15:0] wait_count;
    logic        error_flag;

    assign timeout_hit = (state == ACCESS) && !i_ack && (wait_count == 16'(TIMEOUT - 1));

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            wait_count <= '0;
        end else if (state != ACCESS) begin
            wait_count <= '0;
        end else if (!i_ack) begin
            wait_count <= wait_count + 16'd1;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            error_flag <= 1'b0;
        end else if (state == IDLE) begin
            error_flag <= 1'b0;
        end else if (timeout_hit) begin
            error_flag <= 1'b1;
        end
    end
`else
    logic unused_timeout_cfg;
    assign unused_timeout_cfg = (TIMEOUT > 0);
    assign timeout_hit        = 1'b0;
`endif

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (winner_found) state_next = ACCESS;
            ACCESS:  if (i_ack || timeout_hit) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        o_valid = 1'b0;
        o_done  = '0;
        o_error = '0;
        if (state == ACCESS) begin
            o_valid = 1'b1;
        end
        if (state == DONE) begin
            o_done = grant;
`ifdef RGGEN_ACCESS_ARBITER_TIMEOUT_EN
            if (error_flag) begin
                o_error = grant;
            end
`endif
        end
    end

    // Grant, downstream command and read data registers.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            grant        <= '0;
            grant_idx    <= '0;
            pointer      <= '0;
            o_write      <= 1'b0;
            o_write_data <= '0;
            o_write_mask <= '0;
            o_read_data  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (winner_found) begin
                        grant             <= '0;
                        grant[winner_idx] <= 1'b1;
                        grant_idx         <= winner_idx;
                        o_write           <= i_write[winner_idx];
                        o_write_data      <= i_write_data[int'(winner_idx)*WIDTH +: WIDTH];
                        o_write_mask      <= i_write_mask[int'(winner_idx)*WIDTH +: WIDTH];
                    end
                end
                ACCESS: begin
                    if (i_ack) begin
                        if (!o_write) begin
                            o_read_data <= i_read_data;
                        end
                    end else if (timeout_hit) begin
                        o_read_data <= '0;
                    end
                end
                DONE: begin
                    grant <= '0;
                    if (grant_idx == IDXW'(N - 1)) begin
                        pointer <= '0;
                    end else begin
                        pointer <= grant_idx + IDXW'(1);
                    end
                end
                default: begin
                    grant <= '0;
                end
            endcase
        end
    end

    assign o_grant = grant;

endmodule
